// File: rtl/mult_d.sv
// -----------------------------------------------------------------------------
// mult_d : sequential nb_bit x nb_bit unsigned multiplier, radix-4 iterative.
//
// Produces the raw 2*nb_bit product consumed by the downstream Barrett
// reduction stage. Two multiplier bits are retired per cycle, so a 23-bit
// operand pair takes 12 iterations. Valid/ready handshakes on both sides.
//
// Ports
//   clk_i      in   1          clock, rising edge
//   rst_i      in   1          synchronous active-high reset
//   valid_i    in   1          operands a_i / b_i present
//   ready_o    out  1          block can accept operands (IDLE only)
//   a_i        in   nb_bit     multiplicand, unsigned
//   b_i        in   nb_bit     multiplier, unsigned
//   valid_o    out  1          product_o holds a finished product
//   ready_i    in   1          consumer accepts product_o
//   product_o  out  2*nb_bit   a*b, unsigned
// -----------------------------------------------------------------------------
module mult_d #(
  parameter int nb_bit = 23
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [nb_bit-1:0]     a_i,
  input  logic [nb_bit-1:0]     b_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [2*nb_bit-1:0]   product_o
);

  // Number of radix-4 iterations, multiplier register width (padded to an
  // even number of bits), accumulator width and partial-product width.
  localparam int ITERS = (nb_bit + 1) / 2;
  localparam int B_W   = 2 * ITERS;
  localparam int ACC_W = 2 * nb_bit + 2;
  localparam int PP_W  = nb_bit + 2;
  localparam int CNT_W = $clog2(ITERS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ready;
  logic                  w_accept;
  logic                  w_handoff;
  logic                  w_last;

  logic [nb_bit-1:0]     r_a;
  logic [B_W-1:0]        r_b;
  logic [ACC_W-1:0]      r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*nb_bit-1:0]   r_prod;
  logic                  r_valid;

  logic [PP_W-1:0]       w_pp;
  logic [ACC_W-1:0]      w_pp_sh;
  logic [ACC_W-1:0]      w_acc_nxt;

  // Radix-4 partial product: a times one multiplier digit (0..3).
  function automatic logic [PP_W-1:0] f_pp(input logic [nb_bit-1:0] a,
                                           input logic [1:0]        d);
    logic [PP_W-1:0] ax;
    ax = PP_W'(a);
    case (d)
      2'd0:    f_pp = '0;
      2'd1:    f_pp = ax;
      2'd2:    f_pp = ax << 1;
      default: f_pp = (ax << 1) + ax;
    endcase
  endfunction

  // ---- iteration datapath: digit select, weight by 4^cnt, accumulate ----
  assign w_pp      = f_pp(r_a, r_b[1:0]);
  assign w_pp_sh   = ACC_W'(w_pp) << {r_cnt, 1'b0};
  assign w_acc_nxt = r_acc + w_pp_sh;
  assign w_last    = (r_cnt == CNT_W'(ITERS - 1));

  // ---- control: next-state decode ----
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_handoff   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_i && r_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (r_valid && ready_i) begin
          w_handoff   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ready_o is a registered copy of "next state is IDLE", held low through
  // reset so no operand can be taken while rst_i is asserted. Outside reset
  // it always equals (r_state == S_IDLE).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
    end
  end

  // ---- operand registers: loaded on accept, multiplier shifts in CALC ----
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_a <= a_i;
      r_b <= B_W'(b_i);
    end else if (r_state == S_CALC) begin
      r_b <= r_b >> 2;
    end
  end

  // ---- accumulator, iteration counter and output registers ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == S_CALC) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          // Top two accumulator bits are always zero here: the full product
          // fits in 2*nb_bit bits.
          r_prod  <= w_acc_nxt[2*nb_bit-1:0];
          r_valid <= 1'b1;
        end
      end
      if (w_handoff) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ready_o   = r_ready;
  assign valid_o   = r_valid;
  assign product_o = r_prod;

endmodule

// File: tb/tb_mult_d.sv
module tb_mult_d;

  logic        clk_i;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [22:0] a_i;
  logic [22:0] b_i;
  logic        valid_o;
  logic        ready_i;
  logic [45:0] product_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [45:0] sb_q[$];

  mult_d #(.nb_bit(23)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .product_o (product_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic [22:0] a, input logic [22:0] b);
    logic [45:0] e;
    e = 46'(a) * 46'(b);
    sb_q.push_back(e);
  endtask

  // Issue one job from IDLE; bp = cycles of ready_i low after valid_o rises.
  task automatic run_job(input logic [22:0] a, input logic [22:0] b,
                         input bit churn, input int bp, input string name);
    int          lat;
    logic [45:0] exp_v;
    logic [45:0] got;
    a_i = a; b_i = b; valid_i = 1'b1; ready_i = (bp == 0);
    push_exp(a, b);
    tick();
    valid_i = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s_accept: ready_o=%0b required 0", name, ready_o);
    end
    lat = 0;
    while (valid_o !== 1'b1 && lat < 40) begin
      if (churn) begin
        a_i = 23'($urandom); b_i = 23'($urandom); valid_i = (lat < 10);
      end
      tick();
      lat++;
    end
    valid_i = 1'b0;
    n_cmp++;
    if (lat != 12) begin
      n_err++;
      $display("FAIL %s_latency: got %0d cycles required 12", name, lat);
    end
    got = product_o;
    if (valid_o === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL %s_dup: product %0d with empty scoreboard", name, product_o);
      end else begin
        exp_v = sb_q.pop_front();
        if (product_o !== exp_v) begin
          n_err++;
          $display("FAIL %s_product: got %0d required %0d", name, product_o, exp_v);
        end
      end
    end
    for (int k = 0; k < bp; k++) begin
      valid_i = 1'b1; a_i = 23'($urandom); b_i = 23'($urandom);
      tick();
      n_cmp++;
      if (valid_o !== 1'b1 || product_o !== got || ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL %s_hold: valid_o=%0b product_o=%0d ready_o=%0b required 1/%0d/0",
                 name, valid_o, product_o, ready_o, got);
      end
    end
    valid_i = 1'b0; ready_i = 1'b1;
    tick();
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s_handoff: valid_o=%0b ready_o=%0b required 0/1", name, valid_o, ready_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; a_i = '0; b_i = '0;
    tick(); tick();
    n_cmp++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0 || product_o !== 46'd0) begin
      n_err++;
      $display("FAIL reset_state: ready_o=%0b valid_o=%0b product_o=%0d required 0/0/0",
               ready_o, valid_o, product_o);
    end
    rst_i = 1'b0;
    tick();
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: ready_o=%0b required 1", ready_o);
    end
  endtask

  task automatic test_basic();
    run_job(23'd3, 23'd5, 1'b0, 0, "basic_3x5");
    run_job(23'd0, 23'd8380416, 1'b0, 0, "basic_zero");
  endtask

  task automatic test_extremes();
    run_job(23'd8380416, 23'd8380416, 1'b0, 0, "ext_qm1");
    run_job(23'd8388607, 23'd8388607, 1'b0, 0, "ext_max");
    run_job(23'd4194304, 23'd2, 1'b0, 0, "ext_pow2");
  endtask

  task automatic test_backpressure();
    run_job(23'd1234567, 23'd7654321, 1'b0, 5, "backpressure");
  endtask

  task automatic test_churn();
    run_job(23'd5555555, 23'd3333333, 1'b1, 0, "churn");
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [45:0] exp_v;
    logic [22:0] av[3] = '{23'd11, 23'd8000000, 23'd77};
    logic [22:0] bv[3] = '{23'd13, 23'd8300000, 23'd0};
    ready_i = 1'b1;
    a_i = av[0]; b_i = bv[0]; valid_i = 1'b1;
    push_exp(av[0], bv[0]);
    for (int j = 0; j < 3; j++) begin
      tick();
      n_cmp++;
      if (ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_accept%0d: ready_o=%0b required 0", j, ready_o);
      end
      if (j < 2) begin
        a_i = av[j+1]; b_i = bv[j+1];
        push_exp(av[j+1], bv[j+1]);
      end else begin
        valid_i = 1'b0;
      end
      lat = 0;
      while (valid_o !== 1'b1 && lat < 40) begin
        tick();
        lat++;
      end
      n_cmp++;
      if (lat != 12) begin
        n_err++;
        $display("FAIL b2b_latency%0d: got %0d required 12", j, lat);
      end
      n_cmp++;
      exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 46'h3fff_ffff_ffff;
      if (valid_o !== 1'b1 || product_o !== exp_v) begin
        n_err++;
        $display("FAIL b2b_product%0d: got %0d required %0d", j, product_o, exp_v);
      end
      tick();
      n_cmp++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_handoff%0d: valid_o=%0b ready_o=%0b required 0/1", j, valid_o, ready_o);
      end
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      n_cmp++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_idle: valid_o=%0b ready_o=%0b required 0/1", valid_o, ready_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b1;
    a_i = 23'd1000; b_i = 23'd2000; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0 || product_o !== 46'd0) begin
      n_err++;
      $display("FAIL rstmid_clear: valid_o=%0b product_o=%0d required 0/0", valid_o, product_o);
    end
    tick();
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_ready: ready_o=%0b required 1", ready_o);
    end
    for (int k = 0; k < 14; k++) begin
      tick();
      n_cmp++;
      if (valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL rstmid_novalid: valid_o=%0b required 0", valid_o);
      end
    end
    run_job(23'd7, 23'd9, 1'b0, 0, "rstmid_next");
  endtask

  task automatic test_random();
    int gap;
    for (int n = 0; n < 1500; n++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      run_job(23'($urandom), 23'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), "random");
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL random_lost: %0d products never produced, required 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_churn();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
